// File: rtl/i2s_pkg.sv
// Shared types and default sizes for the I2S transmit path.
package i2s_pkg;

  localparam int DEFAULT_SAMPLE_WIDTH = 16;
  localparam int DEFAULT_SLOT_WIDTH   = 16;
  localparam int DEFAULT_FIFO_DEPTH   = 2;
  localparam int UNDERRUN_CNT_WIDTH   = 16;

  typedef enum logic [1:0] {
    SYNC,
    LEFT,
    RIGHT
  } i2s_state_e;

  typedef struct packed {
    logic [DEFAULT_SAMPLE_WIDTH-1:0] left;
    logic [DEFAULT_SAMPLE_WIDTH-1:0] right;
  } i2s_frame_t;

endpackage

// File: rtl/i2s_tx_serializer_fifo.sv
// Small synchronous FIFO of stereo frames with a first-word-fall-through head.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module i2s_frame_fifo
  import i2s_pkg::*;
#(
  parameter int  DEPTH   = DEFAULT_FIFO_DEPTH,
  parameter type frame_t = i2s_frame_t
) (
  input  logic   i2s_bclk,
  input  logic   reset,
  input  logic   push,
  input  frame_t push_data,
  input  logic   pop,
  output frame_t head,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  frame_t mem [DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem[rd_ptr_q[AW-1:0]];

  // Advance the pointers; reset discards whatever was queued.
  always_ff @(posedge i2s_bclk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push && !full) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop && !empty) rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Frame storage needs no reset because the pointers define validity.
  always_ff @(posedge i2s_bclk) begin
    if (push && !full) mem[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/i2s_tx_serializer.sv
// Philips I2S transmitter: queues stereo frames and shifts them out MSB-first
// one BCLK after each LRCLK edge, substituting silence on mute or underrun.
module i2s_tx_serializer
  import i2s_pkg::*;
#(
  parameter int SAMPLE_WIDTH = DEFAULT_SAMPLE_WIDTH,
  parameter int SLOT_WIDTH   = DEFAULT_SLOT_WIDTH,
  parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
  input  logic                          i2s_bclk,
  input  logic                          reset,
  input  logic                          i2s_lrclk,
  input  logic                          sample_valid,
  input  logic [SAMPLE_WIDTH-1:0]       sample_left,
  input  logic [SAMPLE_WIDTH-1:0]       sample_right,
  output logic                          sample_ready,
  input  logic                          mute,
  output logic                          i2s_sdata,
  output logic                          frame_start,
  output logic                          underrun,
  output logic [UNDERRUN_CNT_WIDTH-1:0] underrun_count
);

  localparam int CNT_W = $clog2(SLOT_WIDTH + 1);
  localparam logic [CNT_W-1:0] SLOT_BITS = CNT_W'(SLOT_WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [UNDERRUN_CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [SAMPLE_WIDTH-1:0] left;
    logic [SAMPLE_WIDTH-1:0] right;
  } frame_t;

  frame_t push_frame;
  frame_t fifo_head;
  logic   fifo_full;
  logic   fifo_empty;
  logic   push;
  logic   pop;

  logic lrclk_q;
  logic left_edge;
  logic right_edge;

  i2s_state_e state_q;
  i2s_state_e state_d;
  logic       load_left;
  logic       load_right;
  logic       underrun_set;

  logic [SLOT_WIDTH-1:0]         shift_q;
  logic [CNT_W-1:0]              bit_cnt_q;
  logic [SAMPLE_WIDTH-1:0]       hold_q;
  logic                          ready_en_q;
  logic                          frame_start_q;
  logic                          underrun_q;
  logic [UNDERRUN_CNT_WIDTH-1:0] underrun_count_q;
  logic [UNDERRUN_CNT_WIDTH-1:0] underrun_count_d;

  // Place a sample at the top of the slot; unused LSBs are transmitted as zero.
  function automatic logic [SLOT_WIDTH-1:0] justify(input logic [SAMPLE_WIDTH-1:0] s);
    logic [SLOT_WIDTH-1:0] w;
    w = '0;
    w[SLOT_WIDTH-1 -: SAMPLE_WIDTH] = s;
    return w;
  endfunction

  assign left_edge    = lrclk_q & ~i2s_lrclk;
  assign right_edge   = ~lrclk_q & i2s_lrclk;
  assign sample_ready = ready_en_q & ~fifo_full;
  assign push         = sample_valid & sample_ready;
  assign pop          = load_left & ~fifo_empty;
  assign underrun_set = load_left & fifo_empty;
  assign push_frame   = '{left: sample_left, right: sample_right};

  assign i2s_sdata      = shift_q[SLOT_WIDTH-1];
  assign frame_start    = frame_start_q;
  assign underrun       = underrun_q;
  assign underrun_count = underrun_count_q;

  i2s_frame_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .frame_t (frame_t)
  ) u_fifo (
    .i2s_bclk  (i2s_bclk),
    .reset     (reset),
    .push      (push),
    .push_data (push_frame),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Slot state register; reset returns to SYNC so output waits for a left edge.
  always_ff @(posedge i2s_bclk) begin
    if (!reset) state_q <= SYNC;
    else        state_q <= state_d;
  end

  // Decide which slot to load; any LRCLK edge restarts a slot even if the last one ran short.
  always_comb begin
    state_d    = state_q;
    load_left  = 1'b0;
    load_right = 1'b0;
    case (state_q)
      SYNC: begin
        if (left_edge) begin
          state_d   = LEFT;
          load_left = 1'b1;
        end
      end
      LEFT, RIGHT: begin
        if (left_edge) begin
          state_d   = LEFT;
          load_left = 1'b1;
        end else if (right_edge) begin
          state_d    = RIGHT;
          load_right = 1'b1;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  // Edge tracking, slot loading and shifting; muted or underrun frames carry zeros in both slots.
  always_ff @(posedge i2s_bclk) begin
    if (!reset) begin
      lrclk_q       <= 1'b1;
      ready_en_q    <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      shift_q       <= '0;
      bit_cnt_q     <= SLOT_BITS;
      hold_q        <= '0;
    end else begin
      lrclk_q       <= i2s_lrclk;
      ready_en_q    <= 1'b1;
      frame_start_q <= load_left;
      underrun_q    <= underrun_set;
      if (load_left) begin
        bit_cnt_q <= '0;
        if (fifo_empty || mute) begin
          shift_q <= '0;
          hold_q  <= '0;
        end else begin
          shift_q <= justify(fifo_head.left);
          hold_q  <= fifo_head.right;
        end
      end else if (load_right) begin
        bit_cnt_q <= '0;
        shift_q   <= justify(hold_q);
      end else if (bit_cnt_q != SLOT_BITS) begin
        bit_cnt_q <= bit_cnt_q + CNT_ONE;
        shift_q   <= shift_q << 1;
      end
    end
  end

  // Saturating underrun tally, bumped on the same edge that raises the pulse.
  always_comb begin
    underrun_count_d = underrun_count_q;
    if (underrun_set && (underrun_count_q != CNT_MAX)) begin
      underrun_count_d = underrun_count_q + 16'd1;
    end
  end

  // Counter register is written every cycle so its value always follows underrun_count_d.
  always_ff @(posedge i2s_bclk) begin
    if (!reset) underrun_count_q <= '0;
    else        underrun_count_q <= underrun_count_d;
  end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed bench for i2s_tx_serializer: a default 16/16 instance and a 12-bit-sample instance.
module tb_i2s_tx_serializer;

  logic i2s_bclk = 1'b0;
  always #5 i2s_bclk = ~i2s_bclk;

  logic        reset_a, lrclk_a, valid_a, mute_a;
  logic [15:0] left_a, right_a;
  logic        ready_a, sdata_a, fs_a, ur_a;
  logic [15:0] count_a;

  logic        reset_b, lrclk_b, valid_b, mute_b;
  logic [11:0] left_b, right_b;
  logic        ready_b, sdata_b, fs_b, ur_b;
  logic [15:0] count_b;

  int checks  = 0;
  int errors  = 0;
  int fs_seen = 0;
  int ur_seen = 0;

  i2s_tx_serializer dut_a (
    .i2s_bclk       (i2s_bclk),
    .reset          (reset_a),
    .i2s_lrclk      (lrclk_a),
    .sample_valid   (valid_a),
    .sample_left    (left_a),
    .sample_right   (right_a),
    .sample_ready   (ready_a),
    .mute           (mute_a),
    .i2s_sdata      (sdata_a),
    .frame_start    (fs_a),
    .underrun       (ur_a),
    .underrun_count (count_a)
  );

  i2s_tx_serializer #(
    .SAMPLE_WIDTH (12),
    .SLOT_WIDTH   (16),
    .FIFO_DEPTH   (2)
  ) dut_b (
    .i2s_bclk       (i2s_bclk),
    .reset          (reset_b),
    .i2s_lrclk      (lrclk_b),
    .sample_valid   (valid_b),
    .sample_left    (left_b),
    .sample_right   (right_b),
    .sample_ready   (ready_b),
    .mute           (mute_b),
    .i2s_sdata      (sdata_b),
    .frame_start    (fs_b),
    .underrun       (ur_b),
    .underrun_count (count_b)
  );

  // Advance one BCLK and settle just after the rising edge.
  task automatic step();
    @(posedge i2s_bclk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one LRCLK half of 'half' BCLKs and check every transmitted bit against 'pattern'.
  task automatic applyStimulus(input int which, input logic lr, input logic [15:0] pattern,
                               input int half, input bit check_fs, input string tag);
    logic obs;
    logic exp_bit;
    logic fs;
    if (which == 0) lrclk_a = lr;
    else            lrclk_b = lr;
    for (int i = 0; i < half; i++) begin
      step();
      obs = (which == 0) ? sdata_a : sdata_b;
      fs  = (which == 0) ? fs_a : fs_b;
      exp_bit = 1'b0;
      if (i < 16) exp_bit = pattern[15 - i];
      checkOutput($sformatf("%s_bit%0d", tag, i), 32'(obs), 32'(exp_bit));
      if (check_fs && (lr == 1'b0) && (i == 0)) checkOutput({tag, "_frame_start"}, 32'(fs), 32'd1);
      if (which == 0) begin
        fs_seen += int'(fs_a);
        ur_seen += int'(ur_a);
      end else begin
        fs_seen += int'(fs_b);
        ur_seen += int'(ur_b);
      end
    end
  endtask

  initial begin
    reset_a = 1'b0; lrclk_a = 1'b1; valid_a = 1'b0; mute_a = 1'b0; left_a = '0; right_a = '0;
    reset_b = 1'b0; lrclk_b = 1'b1; valid_b = 1'b0; mute_b = 1'b0; left_b = '0; right_b = '0;

    // Reset values
    repeat (3) step();
    checkOutput("reset_sdata", 32'(sdata_a), 32'd0);
    checkOutput("reset_ready", 32'(ready_a), 32'd0);
    checkOutput("reset_frame_start", 32'(fs_a), 32'd0);
    checkOutput("reset_underrun", 32'(ur_a), 32'd0);
    checkOutput("reset_count", 32'(count_a), 32'd0);
    reset_a = 1'b1;
    step();
    checkOutput("ready_after_reset", 32'(ready_a), 32'd1);

    // Single frame CAFE/BABE
    valid_a = 1'b1; left_a = 16'hCAFE; right_a = 16'hBABE;
    step();
    valid_a = 1'b0;
    step();
    checkOutput("sync_sdata_idle", 32'(sdata_a), 32'd0);
    fs_seen = 0; ur_seen = 0;
    applyStimulus(0, 1'b0, 16'hCAFE, 16, 1'b1, "t1_left");
    applyStimulus(0, 1'b1, 16'hBABE, 16, 1'b0, "t1_right");
    checkOutput("t1_frame_start_pulses", 32'(fs_seen), 32'd1);
    checkOutput("t1_no_underrun", 32'(ur_seen), 32'd0);

    // Underruns and saturation
    ur_seen = 0;
    repeat (3) begin
      applyStimulus(0, 1'b0, 16'h0000, 16, 1'b1, "t2_left");
      applyStimulus(0, 1'b1, 16'h0000, 16, 1'b0, "t2_right");
    end
    checkOutput("t2_underrun_pulses", 32'(ur_seen), 32'd3);
    checkOutput("t2_count_3", 32'(count_a), 32'd3);
    force dut_a.underrun_count_q = 16'hFFFE;
    step();
    release dut_a.underrun_count_q;
    checkOutput("t2_preload", 32'(count_a), 32'h0000FFFE);
    repeat (2) begin
      applyStimulus(0, 1'b0, 16'h0000, 16, 1'b1, "t2s_left");
      applyStimulus(0, 1'b1, 16'h0000, 16, 1'b0, "t2s_right");
    end
    checkOutput("t2_count_saturated", 32'(count_a), 32'h0000FFFF);

    // Back-to-back pushes into a depth-2 FIFO
    valid_a = 1'b1; left_a = 16'h1111; right_a = 16'h2222;
    checkOutput("t3_ready_first", 32'(ready_a), 32'd1);
    step();
    left_a = 16'h3333; right_a = 16'h4444;
    checkOutput("t3_ready_second", 32'(ready_a), 32'd1);
    step();
    left_a = 16'h5555; right_a = 16'h6666;
    checkOutput("t3_ready_full", 32'(ready_a), 32'd0);
    step();
    valid_a = 1'b0;
    ur_seen = 0;
    applyStimulus(0, 1'b0, 16'h1111, 16, 1'b1, "t3_f1_left");
    applyStimulus(0, 1'b1, 16'h2222, 16, 1'b0, "t3_f1_right");
    applyStimulus(0, 1'b0, 16'h3333, 16, 1'b1, "t3_f2_left");
    applyStimulus(0, 1'b1, 16'h4444, 16, 1'b0, "t3_f2_right");
    applyStimulus(0, 1'b0, 16'h0000, 16, 1'b1, "t3_f3_left");
    applyStimulus(0, 1'b1, 16'h0000, 16, 1'b0, "t3_f3_right");
    checkOutput("t3_third_refused", 32'(ur_seen), 32'd1);

    // Mute with one frame queued
    valid_a = 1'b1; left_a = 16'h7777; right_a = 16'h8888;
    step();
    valid_a = 1'b0;
    mute_a = 1'b1;
    ur_seen = 0;
    applyStimulus(0, 1'b0, 16'h0000, 16, 1'b1, "t4_muted_left");
    mute_a = 1'b0;
    applyStimulus(0, 1'b1, 16'h0000, 16, 1'b0, "t4_muted_right");
    checkOutput("t4_mute_no_underrun", 32'(ur_seen), 32'd0);
    applyStimulus(0, 1'b0, 16'h0000, 16, 1'b1, "t4_next_left");
    applyStimulus(0, 1'b1, 16'h0000, 16, 1'b0, "t4_next_right");
    checkOutput("t4_fifo_empty_after_mute", 32'(ur_seen), 32'd1);

    // Reset in the middle of a left slot
    valid_a = 1'b1; left_a = 16'hCAFE; right_a = 16'hBABE;
    step();
    left_a = 16'hDEAD; right_a = 16'hBEEF;
    step();
    valid_a = 1'b0;
    applyStimulus(0, 1'b0, 16'hCAFE, 7, 1'b1, "t5_left_pre");
    reset_a = 1'b0;
    step();
    checkOutput("t5_reset_sdata", 32'(sdata_a), 32'd0);
    checkOutput("t5_reset_ready", 32'(ready_a), 32'd0);
    step();
    step();
    reset_a = 1'b1;
    applyStimulus(0, 1'b0, 16'h0000, 6, 1'b0, "t5_left_post");
    valid_a = 1'b1; left_a = 16'h1234; right_a = 16'h5678;
    step();
    valid_a = 1'b0;
    applyStimulus(0, 1'b1, 16'h0000, 16, 1'b0, "t5_right_silent");
    applyStimulus(0, 1'b0, 16'h1234, 16, 1'b1, "t5_fresh_left");
    applyStimulus(0, 1'b1, 16'h5678, 16, 1'b0, "t5_fresh_right");

    // 12-bit samples in 16-bit slots, then a short right half
    step();
    checkOutput("t6_reset_ready", 32'(ready_b), 32'd0);
    reset_b = 1'b1;
    step();
    valid_b = 1'b1; left_b = 12'hABC; right_b = 12'h123;
    step();
    left_b = 12'h9A5; right_b = 12'h000;
    step();
    valid_b = 1'b0;
    applyStimulus(1, 1'b0, 16'hABC0, 16, 1'b1, "t6_left");
    applyStimulus(1, 1'b1, 16'h1230, 10, 1'b0, "t6_right_short");
    applyStimulus(1, 1'b0, 16'h9A50, 16, 1'b1, "t6_early_left");
    applyStimulus(1, 1'b1, 16'h0000, 16, 1'b0, "t6_right_zero");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
